// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute ALU with valid/ready handshakes and iterative M-extension unit
module alu_mc #(
  parameter int XLEN    = 32,
  parameter bit EN_M    = 1'b1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_tag,
  output logic            err
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;

  logic            accept;
  logic            is_m, is_div, illegal, div_zero, div_ovf, fast, iter;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, alu_res;
  logic [SHAMT_W-1:0] shamt;

  // Iteration registers: acc is the product high half or the partial remainder,
  // lo is the product low half / multiplier or the quotient / dividend.
  logic [4:0]      op_q;
  logic [XLEN-1:0] acc, lo, b_q, res_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  logic [XLEN:0]     mul_sum, div_diff;
  logic [XLEN-1:0]   acc_n, lo_n, quo, rem, fin_res;
  logic [2*XLEN-1:0] prod, prod_f;

  assign result = res_q;
  assign shamt  = op2[SHAMT_W-1:0];

  // Decode legality, divide fast paths and sign handling of the offered op
  always_comb begin
    is_m     = (op >= 5'd12) && (op <= 5'd19);
    is_div   = (op >= 5'd16) && (op <= 5'd19);
    illegal  = (op > 5'd19) || (is_m && !EN_M);
    div_zero = (op2 == '0);
    div_ovf  = ((op == 5'd16) || (op == 5'd18)) && (op1 == MOST_NEG) && (op2 == '1);
    fast     = is_div && (div_zero || div_ovf);
    iter     = is_m && EN_M && !fast;
    a_neg    = ((op == 5'd13) || (op == 5'd14) || (op == 5'd16) || (op == 5'd18)) && op1[XLEN-1];
    b_neg    = ((op == 5'd13) || (op == 5'd16) || (op == 5'd18)) && op2[XLEN-1];
    a_mag    = a_neg ? -op1 : op1;
    b_mag    = b_neg ? -op2 : op2;
  end

  // Single-cycle results, including the divide corner cases that skip iteration
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:         alu_res = op1 + op2;
      5'd1:         alu_res = op1 - op2;
      5'd2:         alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      5'd3:         alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      5'd4:         alu_res = op1 & op2;
      5'd5:         alu_res = op1 | op2;
      5'd6:         alu_res = op1 ^ op2;
      5'd7:         alu_res = op1 << shamt;
      5'd8:         alu_res = op1 >> shamt;
      5'd9:         alu_res = $signed(op1) >>> shamt;
      5'd10:        alu_res = op1;
      5'd11:        alu_res = op1 + pc;
      5'd16, 5'd17: alu_res = div_zero ? '1 : op1;
      5'd18, 5'd19: alu_res = div_zero ? op1 : '0;
      default:      alu_res = '0;
    endcase
    if (illegal) alu_res = '0;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the final value
  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, b_q} : '0);
    div_diff = {acc, lo[XLEN-1]} - {1'b0, b_q};
    if (op_q[4]) begin
      if (!div_diff[XLEN]) begin
        acc_n = div_diff[XLEN-1:0];
        lo_n  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_n = {acc[XLEN-2:0], lo[XLEN-1]};
        lo_n  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n = mul_sum[XLEN:1];
      lo_n  = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {acc_n, lo_n};
    prod_f = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_n : lo_n;
    rem    = neg_r ? -acc_n : acc_n;
    case (op_q)
      5'd12:               fin_res = prod_f[XLEN-1:0];
      5'd13, 5'd14, 5'd15: fin_res = prod_f[2*XLEN-1:XLEN];
      5'd16, 5'd17:        fin_res = quo;
      default:             fin_res = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Handshakes and next state; flush overrides everything and blocks acceptance
  always_comb begin
    state_d   = state;
    out_valid = (state == DONE);
    in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    accept    = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_d = iter ? BUSY : DONE;
      BUSY: if (cnt == CW'(1)) state_d = DONE;
      DONE: begin
        if (accept)         state_d = iter ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath registers: capture on accept, iterate while busy, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      out_tag <= '0;
      err     <= 1'b0;
      op_q    <= '0;
      acc     <= '0;
      lo      <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
    end else if (!flush) begin
      if (accept) begin
        out_tag <= tag;
        op_q    <= op;
        if (iter) begin
          err   <= 1'b0;
          acc   <= '0;
          lo    <= a_mag;
          b_q   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= CW'(XLEN);
        end else begin
          res_q <= alu_res;
          err   <= illegal;
        end
      end else if (state == BUSY) begin
        acc <= acc_n;
        lo  <= lo_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) res_q <= fin_res;
      end
    end
  end
endmodule
